out_serializer: RTL
===================

Name: out_serializer

Overview:
- Output stage of the nic8 CPU.
- Consumes the CPU output strobe `doOut` with the data-bus value.
- Holds the latest value in an output register `qreg`.
- Queues each value in a small FIFO and transmits it as 8N1 serial on `tx`.
- Lets simulation and hardware observe program output without stalling the CPU; the CPU never waits on this block.

Parameters:
- CLKS_PER_BIT, 4: clock cycles per serial bit. Integer ≥ 2.
- DEPTH, 4: FIFO entries. Power of two, ≥ 2.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- doOut  input  1  CPU output strobe, sampled on posedge clk.
- dbus  input  8  CPU data bus; captured when doOut=1.
- qreg  output  8  last value output by the CPU.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is being transmitted (state ≠ IDLE).
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky flag: a value was dropped because the FIFO was full.

Behaviour:
- Reset (reset_n=0, asynchronous, any time, including mid-frame):
  - qreg=0, tx=1, busy=0, level=0, overflow=0.
  - FIFO pointers=0; state=IDLE; bit and tick counters=0.
  - Any frame in flight is abandoned; tx returns high immediately.
- Capture: on a posedge with doOut=1:
  - qreg<=dbus, always, whether or not the FIFO accepts the value.
  - Push dbus into the FIFO if level<DEPTH, or if a pop occurs on the same edge.
  - Otherwise discard the value and set overflow<=1. overflow clears only on reset.
- Pop: occurs on a posedge where state=IDLE and level>0.
  - Head byte moves into an 8-bit shift register.
  - state<=START, tick counter<=0.
- Level arithmetic:
  - push only: +1; pop only: −1; push and pop on the same edge: unchanged.
  - Pointers wrap modulo DEPTH.
  - level never exceeds DEPTH and never goes below 0.
- Transmit FSM, with a tick counter running 0..CLKS_PER_BIT−1:
  - IDLE: tx=1. Transition to START on pop.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index=0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right and increment the index. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Outputs are registered: tx, busy and level reflect state after the edge; no combinational path from inputs to outputs.
- Latency: doOut at edge N with the FIFO empty and state IDLE:
  - level=1 after N.
  - Pop at N+1: tx falls and busy rises after N+1.
  - Frame occupies 10×CLKS_PER_BIT cycles.
  - Back in IDLE after edge N+1+10×CLKS_PER_BIT.
- Back-to-back frames: a non-empty FIFO at the STOP→IDLE transition pops on the next edge. This gives exactly one idle-high cycle between frames.
- Values are never reordered or duplicated. Each accepted byte is transmitted exactly once.

Test Plan:
- Single byte, CLKS_PER_BIT=4: reset, then doOut=1 with dbus=8'hA5 for one cycle.
  - qreg=A5 next cycle.
  - tx sequence, sampled mid-bit: 0, 1,0,1,0,0,1,0,1, 1 (start, LSB-first data, stop).
  - busy high for exactly 40 cycles.
- Burst: doOut on 4 consecutive cycles with 01, 02, 03, 04.
  - level peaks at 3, since the first value pops during the burst.
  - Four frames decode as 01, 02, 03, 04, each separated by one idle cycle.
  - overflow=0.
- Overflow: DEPTH=4; push 6 values (10..15) while the first frame is in flight.
  - qreg=15.
  - overflow=1 and remains 1.
  - Decoded output is exactly 10, 11, 12, 13, 14; the sixth value is dropped.
- Simultaneous push/pop at full: fill the FIFO to level=4 with state IDLE, then assert doOut with dbus=77 on the pop edge.
  - level stays 4, overflow=0.
  - 77 is transmitted last.
- Reset mid-frame: assert reset_n=0 during DATA bit 3, asynchronously between edges.
  - Immediately: tx=1, busy=0, level=0, qreg=0.
  - After release, a new byte 3C transmits correctly.
- No strobe: 100 cycles with doOut=0 and dbus toggling randomly.
  - qreg unchanged, tx=1 constant, level=0.

Source files
------------

// File: rtl/out_serializer.sv
// Output stage of the nic8 CPU: latches each output byte into qreg, queues it in a
// small FIFO and transmits it as 8N1 serial on tx without ever stalling the CPU.
module out_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     doOut,
  input  logic [7:0]               dbus,
  output logic [7:0]               qreg,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int TICK_W = $clog2(CLKS_PER_BIT);

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t              state_q;
  logic [TICK_W-1:0]   tick_q;
  logic [2:0]          bitIdx_q;
  logic [7:0]          shift_q;
  logic                tx_q;
  logic                busy_q;

  logic [7:0]          mem_q [DEPTH];
  logic [PTR_W-1:0]    wrPtr_q;
  logic [PTR_W-1:0]    rdPtr_q;
  logic [LVL_W-1:0]    level_q;
  logic [LVL_W-1:0]    level_d;
  logic [7:0]          qreg_q;
  logic                overflow_q;

  logic                pop;
  logic                push;
  logic                lastTick;

  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign pop      = (state_q == IDLE) && (level_q != '0);
  assign push     = doOut && ((level_q != FULL_LVL) || pop);
  assign lastTick = (tick_q == LAST_TICK);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      qreg_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      level_q <= level_d;
      if (push) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      if (doOut) begin
        qreg_q <= dbus;
        if (!push) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= dbus;
    end
  end

  // tx is loaded with the level of the bit that starts after each edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (pop) begin
            state_q <= START;
            shift_q <= mem_q[rdPtr_q];
            tick_q  <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (lastTick) begin
            state_q  <= DATA;
            tick_q   <= '0;
            bitIdx_q <= '0;
            tx_q     <= shift_q[0];
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        DATA: begin
          if (lastTick) begin
            tick_q <= '0;
            if (bitIdx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q  <= shift_q >> 1;
              bitIdx_q <= bitIdx_q + 3'd1;
              tx_q     <= shift_q[1];
            end
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        STOP: begin
          if (lastTick) begin
            state_q <= IDLE;
            tick_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tick_q  <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign qreg     = qreg_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule
